// File: rtl/l2_sclk_edge_gen.sv
// SPI serial-clock edge generator: in master mode it divides clk into SCLK/CS_n for one transfer,
// in slave mode it synchronizes external SCLK/CS_n. Either way it reports SCLK edges as one-clk pulses.
module l2_sclk_edge_gen #(
    parameter logic M_OR_S      = 1'b1,
    parameter logic CPOL        = 1'b0,
    parameter int   CLK_DIV     = 4,
    parameter int   DIV_WIDTH   = 8,
    parameter int   BIT_NUM     = 8,
    parameter int   EDGE_WIDTH  = 5,
    parameter int   HOLD_CYCLES = 24,
    parameter int   HOLD_WIDTH  = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic im_start,
    input  logic im_sclk,
    input  logic im_cs_n,
    output logic om_sclk,
    output logic om_cs_n,
    output logic om_work_en,
    output logic om_up_edge,
    output logic om_down_edge,
    output logic om_busy,
    output logic om_done
);

    // state | meaning
    // IDLE  | waiting for im_start, CS_n high
    // SETUP | CS_n low, one SCLK half-period before the first edge
    // RUN   | SCLK toggling, 2*BIT_NUM edges
    // HOLD  | CS_n held low so delayed downstream reads still land in the window
    // DONE  | one cycle: CS_n released, done pulse
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_HOLD, S_DONE} state_t;

    localparam logic [DIV_WIDTH-1:0]  DIV_LAST  = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [EDGE_WIDTH-1:0] EDGE_LAST = EDGE_WIDTH'(2 * BIT_NUM - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
    logic [EDGE_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
    logic [HOLD_WIDTH-1:0]  hold_cnt_q, hold_cnt_d;
    logic                   toggle;

    logic m_sclk_q, m_sclk_d, m_cs_n_q, m_cs_n_d, m_work_en_q, m_work_en_d;
    logic m_up_q, m_up_d, m_dn_q, m_dn_d, m_busy_q, m_busy_d, m_done_q, m_done_d;

    logic s_sclk_meta_q, s_sclk_meta_d, s_sclk_sync_q, s_sclk_sync_d, s_sclk_prev_q, s_sclk_prev_d;
    logic s_cs_meta_q, s_cs_meta_d, s_cs_sync_q, s_cs_sync_d, s_cs_prev_q, s_cs_prev_d;
    logic s_up_q, s_up_d, s_dn_q, s_dn_d, s_done_q, s_done_d, s_work_q, s_work_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            div_cnt_q     <= '0;
            edge_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            m_sclk_q      <= CPOL;
            m_cs_n_q      <= 1'b1;
            m_work_en_q   <= 1'b0;
            m_up_q        <= 1'b0;
            m_dn_q        <= 1'b0;
            m_busy_q      <= 1'b0;
            m_done_q      <= 1'b0;
            s_sclk_meta_q <= CPOL;
            s_sclk_sync_q <= CPOL;
            s_sclk_prev_q <= CPOL;
            s_cs_meta_q   <= 1'b1;
            s_cs_sync_q   <= 1'b1;
            s_cs_prev_q   <= 1'b1;
            s_up_q        <= 1'b0;
            s_dn_q        <= 1'b0;
            s_done_q      <= 1'b0;
            s_work_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            m_sclk_q      <= m_sclk_d;
            m_cs_n_q      <= m_cs_n_d;
            m_work_en_q   <= m_work_en_d;
            m_up_q        <= m_up_d;
            m_dn_q        <= m_dn_d;
            m_busy_q      <= m_busy_d;
            m_done_q      <= m_done_d;
            s_sclk_meta_q <= s_sclk_meta_d;
            s_sclk_sync_q <= s_sclk_sync_d;
            s_sclk_prev_q <= s_sclk_prev_d;
            s_cs_meta_q   <= s_cs_meta_d;
            s_cs_sync_q   <= s_cs_sync_d;
            s_cs_prev_q   <= s_cs_prev_d;
            s_up_q        <= s_up_d;
            s_dn_q        <= s_dn_d;
            s_done_q      <= s_done_d;
            s_work_q      <= s_work_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        hold_cnt_d = hold_cnt_q;
        toggle     = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_cnt_d  = '0;
                edge_cnt_d = '0;
                hold_cnt_d = '0;
                if (im_start) state_d = S_SETUP;
            end
            S_SETUP: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    state_d    = S_RUN;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d  = '0;
                    toggle     = 1'b1;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (edge_cnt_q == EDGE_LAST) begin
                        hold_cnt_d = '0;
                        state_d    = S_HOLD;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) state_d = S_DONE;
                else                         hold_cnt_d = hold_cnt_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        m_sclk_d    = toggle ? ~m_sclk_q : m_sclk_q;
        m_up_d      = toggle & ~m_sclk_q;
        m_dn_d      = toggle &  m_sclk_q;
        m_cs_n_d    = !(state_d == S_SETUP || state_d == S_RUN || state_d == S_HOLD);
        m_work_en_d = ~m_cs_n_d;
        m_busy_d    = (state_d != S_IDLE);
        m_done_d    = (state_d == S_DONE);

        s_sclk_meta_d = im_sclk;
        s_sclk_sync_d = s_sclk_meta_q;
        s_sclk_prev_d = s_sclk_sync_q;
        s_cs_meta_d   = im_cs_n;
        s_cs_sync_d   = s_cs_meta_q;
        s_cs_prev_d   = s_cs_sync_q;
        s_up_d        =  s_sclk_sync_q & ~s_sclk_prev_q & ~s_cs_sync_q;
        s_dn_d        = ~s_sclk_sync_q &  s_sclk_prev_q & ~s_cs_sync_q;
        s_done_d      =  s_cs_sync_q & ~s_cs_prev_q;
        s_work_d      = ~s_cs_sync_q;
    end

    assign om_sclk      = M_OR_S ? m_sclk_q    : CPOL;
    assign om_cs_n      = M_OR_S ? m_cs_n_q    : 1'b1;
    assign om_work_en   = M_OR_S ? m_work_en_q : s_work_q;
    assign om_up_edge   = M_OR_S ? m_up_q      : s_up_q;
    assign om_down_edge = M_OR_S ? m_dn_q      : s_dn_q;
    assign om_busy      = M_OR_S ? m_busy_q    : s_work_q;
    assign om_done      = M_OR_S ? m_done_q    : s_done_q;

endmodule

// File: doc/l2_sclk_edge_gen.md
Name: l2_sclk_edge_gen

Overview:
- Produces the SPI serial clock and the edge pulses (om_up_edge / om_down_edge) that drive the L3 read/write pulse generator and the shift registers.
- Master mode: divides clk to generate SCLK and CS_n for one BIT_NUM-bit transfer per start request.
- Slave mode: synchronizes external SCLK/CS_n and reports their edges.
- Sits between the L1 transfer controller and L3 pulse creation.

Parameters:
M_OR_S, 1'b1, 1 = master (generate SCLK), 0 = slave (detect SCLK)
CPOL, 1'b0, SCLK idle level; master drives om_sclk to CPOL when idle
CLK_DIV, 4, clk cycles per SCLK half-period (master); legal range 2..2^DIV_WIDTH-1
DIV_WIDTH, 8, width of half-period counter
BIT_NUM, 8, bits per transfer (master); edges per transfer = 2*BIT_NUM
EDGE_WIDTH, 5, width of edge counter; must hold 2*BIT_NUM
HOLD_CYCLES, 24, clk cycles CS_n stays low after last edge; must exceed the downstream read delay (20) so the last delayed read pulse lands while om_work_en=1
HOLD_WIDTH, 6, width of hold counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
im_start  input  1  master: request one transfer; sampled only in IDLE
im_sclk  input  1  slave: external SCLK (asynchronous)
im_cs_n  input  1  slave: external chip select, active-low (asynchronous)
om_sclk  output  1  master: SCLK; slave: constant CPOL
om_cs_n  output  1  master: chip select; slave: constant 1
om_work_en  output  1  transfer window, feeds L3 im_work_en
om_up_edge  output  1  one-clk pulse, SCLK rising edge
om_down_edge  output  1  one-clk pulse, SCLK falling edge
om_busy  output  1  transfer in progress
om_done  output  1  one-clk pulse at end of transfer

Behaviour:
- All outputs are registered. Reset values: om_sclk=CPOL, om_cs_n=1, om_work_en=0, om_up_edge=0, om_down_edge=0, om_busy=0, om_done=0. All counters clear to 0. State goes to IDLE.
- Synchronous rst overrides everything, including mid-transfer: outputs take reset values on the next clk edge and no edge pulse is emitted.
- Master FSM states: IDLE, SETUP, RUN, HOLD, DONE.
- IDLE:
  - im_start=1 -> SETUP.
  - In the next cycle: om_cs_n=0, om_work_en=1, om_busy=1.
- SETUP:
  - Lasts exactly CLK_DIV cycles, then -> RUN with div_cnt=0 and edge_cnt=0.
- RUN:
  - div_cnt increments every cycle.
  - At div_cnt==CLK_DIV-1: div_cnt wraps to 0, om_sclk toggles, edge_cnt increments.
  - The edge pulse is asserted in the same cycle the new om_sclk level appears: om_up_edge if the new level is 1, om_down_edge if it is 0.
  - After toggle number 2*BIT_NUM, om_sclk equals CPOL again -> HOLD.
  - CPOL=0: the first pulse is up. CPOL=1: the first pulse is down.
- HOLD:
  - HOLD_CYCLES cycles with no toggles, then -> DONE.
- DONE (one cycle):
  - om_cs_n=1, om_work_en=0, om_done=1, om_busy still 1.
  - Then -> IDLE with om_busy=0.
- Timing with im_start sampled in cycle 0:
  - cs_n falls at cycle 1.
  - Edge k (k=0..2*BIT_NUM-1) occurs at cycle 1+2*CLK_DIV+k*CLK_DIV.
  - DONE occurs at last edge + HOLD_CYCLES.
- im_start is ignored in every state except IDLE; it is not queued.
- om_up_edge and om_down_edge are never high together, and are never high outside RUN.
- Slave mode:
  - im_sclk and im_cs_n each pass through a 2-flop synchronizer; a third register holds the previous synchronized sclk.
  - om_up_edge = prev 0, current 1, and synchronized cs_n=0. om_down_edge is the converse.
  - Latency: 3 clk cycles from the im_sclk transition to the pulse.
  - om_work_en = om_busy = inverted synchronized cs_n, registered.
  - om_done pulses one cycle on a synchronized cs_n 0->1 transition.
  - SCLK edges while cs_n is high produce no pulses.
  - If cs_n rises in the same cycle as an SCLK edge, the edge is suppressed.
  - im_start is ignored.

Test Plan:
- Master, CPOL=0, CLK_DIV=4, BIT_NUM=8, HOLD_CYCLES=24, im_start at cycle 0:
  - om_cs_n falls at cycle 1.
  - om_up_edge at 9, 17, ..., 65; om_down_edge at 13, 21, ..., 69 (8 each).
  - om_done and om_cs_n rise at 93; om_busy falls at 94.
- Master, CPOL=1, same settings:
  - om_sclk idles at 1; first pulse is om_down_edge at cycle 9.
  - om_sclk returns to 1 after 16 edges.
- Master: im_start pulsed again at cycle 40 while busy -> ignored; exactly 16 edges and one om_done. A new im_start at cycle 94 starts a second transfer with om_cs_n low at 95.
- Master: rst asserted at cycle 30 -> at cycle 31 om_sclk=CPOL, om_cs_n=1, om_work_en=0, om_busy=0, no pulses. im_start after rst releases behaves as in the first scenario.
- Slave, CPOL=0, im_cs_n=0: toggle im_sclk 0->1 at cycle 10 -> om_up_edge at cycle 13. 1->0 at cycle 20 -> om_down_edge at cycle 23.
- Slave: im_sclk toggles while im_cs_n=1 -> no pulses. im_cs_n 0->1 at cycle 50 -> om_done at cycle 53 and om_work_en low from cycle 53.
